fp_addsub_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor, successor to the team's fixed half-precision pipelined adder. It adds configurable exponent/mantissa widths, a per-operation add/subtract select, round-to-nearest-even, special-value handling (zero, infinity, NaN), exception flags and a valid/ready handshake with backpressure. It sits in the FP datapath wherever a streaming add/sub is needed. Default parameters give binary16.

---
 rtl/fp_pkg.sv | 42 ++++
 rtl/fp_lzc.sv | 26 ++
 rtl/fp_addsub_pipe.sv | 254 +++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point add/sub pipeline:
// default widths, flag positions, operand classes and special-value encodings.
package fp_pkg;

  localparam int unsigned ExpWDefault = 5;
  localparam int unsigned ManWDefault = 10;

  localparam int unsigned NumFlags      = 4;
  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  typedef enum logic [1:0] {
    ClsZero,
    ClsNorm,
    ClsInf,
    ClsNan
  } fp_class_e;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Encodings are built in a 64-bit word; callers slice the low 1+exp_w+man_w bits.
  function automatic logic [63:0] inf_word(input int unsigned exp_w, input int unsigned man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] qnan_word(input int unsigned exp_w, input int unsigned man_w);
    return inf_word(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic man_zero);
    if (exp_zero) return ClsZero;
    if (!exp_ones) return ClsNorm;
    if (man_zero) return ClsInf;
    return ClsNan;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; cnt_o equals Width when the input is all zero.
module fp_lzc #(
  parameter int unsigned Width = 14,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             zero_o
);

  logic found;

  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        found = 1'b1;
      end else if (!found) begin
        cnt_o = cnt_o + CntW'(1);
      end
    end
    zero_o = ~found;
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage streaming floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero, special-value handling and a global-stall valid/ready handshake.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = ExpWDefault,
  parameter int unsigned MAN_W = ManWDefault
) (
  input  logic                 clk_59,
  input  logic                 rst_59,
  input  logic                 in_valid_59,
  output logic                 in_ready_59,
  input  logic [EXP_W+MAN_W:0] a_59,
  input  logic [EXP_W+MAN_W:0] b_59,
  input  logic                 sub_59,
  output logic                 out_valid_59,
  input  logic                 out_ready_59,
  output logic [EXP_W+MAN_W:0] c_59,
  output logic [NumFlags-1:0]  flags_59
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SigW = MAN_W + 1;
  localparam int unsigned ExtW = MAN_W + 4;
  localparam int unsigned AlW  = 2 * MAN_W + 5;
  localparam int unsigned CntW = $clog2(ExtW + 1);
  localparam int unsigned EW   = ((EXP_W > CntW) ? EXP_W : CntW) + 2;

  localparam logic [63:0]   InfWide  = inf_word(EXP_W, MAN_W);
  localparam logic [63:0]   QnanWide = qnan_word(EXP_W, MAN_W);
  localparam logic [W-1:0]  InfPos   = InfWide[W-1:0];
  localparam logic [W-1:0]  Qnan     = QnanWide[W-1:0];
  localparam logic [EW-1:0] ExpMax   = EW'({EXP_W{1'b1}});

  typedef struct packed {
    logic             special;
    logic [W-1:0]     spec_word;
    logic             spec_inv;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_x;
  } ctl_t;

  typedef struct packed {
    ctl_t             ctl;
    logic [EXP_W-1:0] diff;
    logic [SigW-1:0]  sig_x;
    logic [SigW-1:0]  sig_y;
  } s1_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [ExtW-1:0] mx;
    logic [ExtW-1:0] my;
  } s2_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [ExtW:0]   sum;
    logic [CntW-1:0] lzc;
    logic            zero;
  } s3_t;

  logic                en;
  logic                s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q, s3_valid_d, s3_valid_q;
  logic                out_valid_d, out_valid_q;
  s1_t                 s1_d, s1_q;
  s2_t                 s2_d, s2_q;
  s3_t                 s3_d, s3_q;
  logic [W-1:0]        c_d, c_q;
  logic [NumFlags-1:0] flags_d, flags_q;

  assign en           = !out_valid_q || out_ready_59;
  assign in_ready_59  = en;
  assign out_valid_59 = out_valid_q;
  assign c_59         = c_q;
  assign flags_59     = flags_q;

  always_comb begin
    s1_valid_d  = in_valid_59;
    s2_valid_d  = s1_valid_q;
    s3_valid_d  = s2_valid_q;
    out_valid_d = s3_valid_q;
  end

  // S1: unpack, classify, resolve specials, order operands by magnitude.
  logic             sa, sb, a_ge_b;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  fp_class_e        cls_a, cls_b;

  always_comb begin
    sa    = a_59[W-1];
    ea    = a_59[W-2:MAN_W];
    ma    = a_59[MAN_W-1:0];
    sb    = b_59[W-1] ^ sub_59;
    eb    = b_59[W-2:MAN_W];
    mb    = b_59[MAN_W-1:0];
    cls_a = classify(&ea, ~|ea, ~|ma);
    cls_b = classify(&eb, ~|eb, ~|mb);
    if (cls_a == ClsZero) ma = '0;
    if (cls_b == ClsZero) mb = '0;
    a_ge_b = {ea, ma} >= {eb, mb};

    s1_d                  = '0;
    s1_d.ctl.special      = 1'b1;
    s1_d.ctl.eff_sub      = sa ^ sb;
    if (cls_a == ClsNan || cls_b == ClsNan) begin
      s1_d.ctl.spec_word  = Qnan;
      s1_d.ctl.spec_inv   = 1'b1;
    end else if (cls_a == ClsInf && cls_b == ClsInf && sa != sb) begin
      s1_d.ctl.spec_word  = Qnan;
      s1_d.ctl.spec_inv   = 1'b1;
    end else if (cls_a == ClsInf) begin
      s1_d.ctl.spec_word  = {sa, InfPos[W-2:0]};
    end else if (cls_b == ClsInf) begin
      s1_d.ctl.spec_word  = {sb, InfPos[W-2:0]};
    end else if (cls_a == ClsZero && cls_b == ClsZero) begin
      s1_d.ctl.spec_word  = {sa & sb, {(W-1){1'b0}}};
    end else begin
      s1_d.ctl.special    = 1'b0;
    end

    if (a_ge_b) begin
      s1_d.ctl.sign  = sa;
      s1_d.ctl.exp_x = ea;
      s1_d.diff      = ea - eb;
      s1_d.sig_x     = {cls_a != ClsZero, ma};
      s1_d.sig_y     = {cls_b != ClsZero, mb};
    end else begin
      s1_d.ctl.sign  = sb;
      s1_d.ctl.exp_x = eb;
      s1_d.diff      = eb - ea;
      s1_d.sig_x     = {cls_b != ClsZero, mb};
      s1_d.sig_y     = {cls_a != ClsZero, ma};
    end
  end

  // S2: align Y into {sig, guard, round, sticky}.
  logic [AlW-1:0] wide, shifted;
  logic           far;

  always_comb begin
    s2_d     = '0;
    s2_d.ctl = s1_q.ctl;
    wide     = {s1_q.sig_y, {ExtW{1'b0}}};
    shifted  = wide >> s1_q.diff;
    far      = 32'(s1_q.diff) >= MAN_W + 3;
    s2_d.mx  = {s1_q.sig_x, 3'b000};
    if (far) begin
      s2_d.my = {{(ExtW-1){1'b0}}, |s1_q.sig_y};
    end else begin
      s2_d.my = {shifted[AlW-1:MAN_W+2], |shifted[MAN_W+1:0]};
    end
  end

  // S3: magnitude add/subtract; X >= Y so the difference is never negative.
  logic [ExtW:0]   sum;
  logic [CntW-1:0] lzc;
  logic            lzc_zero;

  always_comb begin
    if (s2_q.ctl.eff_sub) sum = {1'b0, s2_q.mx} - {1'b0, s2_q.my};
    else                  sum = {1'b0, s2_q.mx} + {1'b0, s2_q.my};
    s3_d      = '0;
    s3_d.ctl  = s2_q.ctl;
    s3_d.sum  = sum;
    s3_d.lzc  = lzc;
    s3_d.zero = lzc_zero;
  end

  fp_lzc #(
    .Width(ExtW),
    .CntW (CntW)
  ) u_lzc (
    .in_i  (sum[ExtW-1:0]),
    .cnt_o (lzc),
    .zero_o(lzc_zero)
  );

  // S4: normalise, round to nearest even, detect range exceptions, pack.
  logic [EW-1:0]    e_norm, e_rnd;
  logic [ExtW-1:0]  norm;
  logic [SigW-1:0]  mant;
  logic [SigW:0]    rounded;
  logic [MAN_W-1:0] man_out;
  logic             g, r, s, rnd_up;

  always_comb begin
    norm   = s3_q.sum[ExtW-1:0] << s3_q.lzc;
    e_norm = EW'(s3_q.ctl.exp_x) - EW'(s3_q.lzc);
    if (s3_q.sum[ExtW]) begin
      norm   = {s3_q.sum[ExtW:2], s3_q.sum[1] | s3_q.sum[0]};
      e_norm = EW'(s3_q.ctl.exp_x) + EW'(1);
    end
    mant    = norm[ExtW-1:3];
    g       = norm[2];
    r       = norm[1];
    s       = norm[0];
    rnd_up  = g & (r | s | mant[0]);
    rounded = {1'b0, mant} + (SigW + 1)'(rnd_up);
    e_rnd   = e_norm;
    man_out = rounded[MAN_W-1:0];
    if (rounded[SigW]) begin
      e_rnd   = e_norm + EW'(1);
      man_out = rounded[MAN_W:1];
    end

    c_d                  = {s3_q.ctl.sign, e_rnd[EXP_W-1:0], man_out};
    flags_d              = '0;
    flags_d[FlagInexact] = g | r | s;
    if (s3_q.ctl.special) begin
      c_d                  = s3_q.ctl.spec_word;
      flags_d              = '0;
      flags_d[FlagInvalid] = s3_q.ctl.spec_inv;
    end else if (s3_q.ctl.eff_sub && s3_q.zero) begin
      c_d     = '0;
      flags_d = '0;
    end else if (e_norm[EW-1] || e_norm == '0) begin
      c_d                    = {s3_q.ctl.sign, {(W-1){1'b0}}};
      flags_d                = '0;
      flags_d[FlagUnderflow] = 1'b1;
      flags_d[FlagInexact]   = 1'b1;
    end else if (e_rnd >= ExpMax) begin
      c_d                   = {s3_q.ctl.sign, InfPos[W-2:0]};
      flags_d               = '0;
      flags_d[FlagOverflow] = 1'b1;
      flags_d[FlagInexact]  = 1'b1;
    end
  end

  // Data registers only need the stall enable; valids and outputs also clear on reset.
  always_ff @(posedge clk_59) begin
    if (rst_59) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
    end else if (en) begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      c_q         <= c_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed binary16 vectors, a stalled burst,
// mid-stream reset, and a binary32 instance.
module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] c;
    logic [3:0]  f;
  } vec_t;

  typedef struct packed {
    logic [15:0] c;
    logic [3:0]  f;
    logic        lat;
    int          t;
  } exp_t;

  localparam int NumVec = 13;

  // flags = {invalid, overflow, underflow, inexact}
  vec_t vecs [NumVec] = '{
    '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'h0},
    '{16'h4200, 16'h3C00, 1'b1, 16'h4000, 4'h0},
    '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'h0},
    '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0},
    '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5},
    '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'h8},
    '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'h8},
    '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'h0},
    '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'h1},
    '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'h1},
    '{16'h0400, 16'h03FF, 1'b1, 16'h0400, 4'h0},
    '{16'h0401, 16'h0400, 1'b1, 16'h0000, 4'h3},
    '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'h8}
  };

  // k + 1.0 for k = 1..10
  logic [15:0] burst_a [10] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900};
  logic [15:0] burst_c [10] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
                                16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [15:0] a, b, c;
  logic [3:0]  flags;
  logic        in_valid32, in_ready32, sub32, out_valid32;
  logic        out_ready32 = 1'b1;
  logic [31:0] a32, b32, c32;
  logic [3:0]  flags32;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          idx;
  exp_t        sbq[$];
  logic [35:0] sbq32[$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_c;
  logic [3:0]  prev_f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_addsub_pipe u_dut16 (
    .clk_59      (clk),
    .rst_59      (rst),
    .in_valid_59 (in_valid),
    .in_ready_59 (in_ready),
    .a_59        (a),
    .b_59        (b),
    .sub_59      (sub),
    .out_valid_59(out_valid),
    .out_ready_59(out_ready),
    .c_59        (c),
    .flags_59    (flags)
  );

  fp_addsub_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) u_dut32 (
    .clk_59      (clk),
    .rst_59      (rst),
    .in_valid_59 (in_valid32),
    .in_ready_59 (in_ready32),
    .a_59        (a32),
    .b_59        (b32),
    .sub_59      (sub32),
    .out_valid_59(out_valid32),
    .out_ready_59(out_ready32),
    .c_59        (c32),
    .flags_59    (flags32)
  );

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk(out_valid && c == prev_c && flags == prev_f, "stall_hold",
            {11'h0, out_valid, flags, c}, {11'h0, 1'b1, prev_f, prev_c});
      end
      if (out_valid && out_ready) begin
        chk(sbq.size() != 0, "unexpected_beat", 32'(c), 32'h0);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk(c == e.c, "result16", 32'(c), 32'(e.c));
          chk(flags == e.f, "flags16", 32'(flags), 32'(e.f));
          if (e.lat) chk(cyc - e.t == 4, "latency", 32'(cyc - e.t), 32'd4);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
      prev_f     = flags;
    end
  end

  always @(negedge clk) begin
    logic [35:0] e32;
    if (!rst && out_valid32) begin
      chk(sbq32.size() != 0, "unexpected_beat32", c32, 32'h0);
      if (sbq32.size() != 0) begin
        e32 = sbq32.pop_front();
        chk(c32 == e32[35:4], "result32", c32, e32[35:4]);
        chk(flags32 == e32[3:0], "flags32", 32'(flags32), 32'(e32[3:0]));
      end
    end
  end

  task automatic send(input vec_t v, input bit lat);
    bit   done = 1'b0;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    sub      = v.s;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.c  = v.c;
        e.f  = v.f;
        e.lat = lat;
        e.t  = cyc;
        sbq.push_back(e);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk(done, "accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || sbq32.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(sbq.size() == 0 && sbq32.size() == 0, "drain", 32'(sbq.size() + sbq32.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v32 [2][3];
    bit          exp_rdy;
    v32[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    v32[1] = '{32'h40400000, 32'h3F800000, 32'h40000000};

    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    sub        = 1'b0;
    out_ready  = 1'b1;
    in_valid32 = 1'b0;
    a32        = '0;
    b32        = '0;
    sub32      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(!out_valid, "rst_out_valid", 32'(out_valid), 32'd0);
    chk(in_ready, "rst_in_ready", 32'(in_ready), 32'd1);
    chk(c == 16'h0, "rst_c", 32'(c), 32'd0);
    chk(flags == 4'h0, "rst_flags", 32'(flags), 32'd0);

    for (int i = 0; i < NumVec; i++) send(vecs[i], i == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Burst with downstream stalled on cycles 7..10, while the output is occupied.
    idx = 0;
    for (int i = 0; i < 40 && idx < 10; i++) begin
      @(posedge clk);
      #1;
      exp_rdy   = !(i >= 7 && i <= 10);
      out_ready = exp_rdy;
      in_valid  = 1'b1;
      a         = burst_a[idx];
      b         = 16'h3C00;
      sub       = 1'b0;
      @(negedge clk);
      chk(in_ready == exp_rdy, "burst_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (in_ready) begin
        sbq.push_back('{c: burst_c[idx], f: 4'h0, lat: 1'b0, t: cyc});
        idx++;
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk(idx == 10, "burst_count", 32'(idx), 32'd10);
    drain();

    // Three beats in flight, then a one-cycle reset: none of them may emerge.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = 16'h4000;
      b        = 16'h4000;
      sub      = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(!out_valid, "midrst_out_valid", 32'(out_valid), 32'd0);
    chk(in_ready, "midrst_in_ready", 32'(in_ready), 32'd1);
    chk(c == 16'h0, "midrst_c", 32'(c), 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk(!out_valid, "no_stale", 32'(out_valid), 32'd0);
    end

    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      in_valid32 = 1'b1;
      a32        = v32[k][0];
      b32        = v32[k][1];
      sub32      = (k == 1);
      @(negedge clk);
      chk(in_ready32, "in_ready32", 32'(in_ready32), 32'd1);
      if (in_ready32) sbq32.push_back({v32[k][2], 4'h0});
    end
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    drain();

    chk(sbq.size() == 0 && sbq32.size() == 0, "scoreboard_empty",
        32'(sbq.size() + sbq32.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
